// File: rtl/mul_pkg.sv
// Shared types for the RV32M multiply issue/retire wrapper: op encoding and
// the payload carried by each of the two pipeline stages.
package mul_pkg;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_e;

  typedef struct packed {
    mul_op_e          op;
    logic [TAG_W-1:0] rd;
    logic             neg;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
  } s1_t;

  typedef struct packed {
    mul_op_e           op;
    logic [TAG_W-1:0]  rd;
    logic              neg;
    logic [2*XLEN-1:0] prod;
  } s2_t;

endpackage

// File: rtl/mul_sign_fix.sv
// Re-applies the operand sign to the unsigned core product and picks the
// low word for MUL or the high word for the MULH variants.
module mul_sign_fix
  import mul_pkg::*;
(
  input  logic [2*XLEN-1:0] prod,
  input  logic              neg,
  input  mul_op_e           op,
  output logic [XLEN-1:0]   result
);

  logic signed [2*XLEN-1:0] prod_s;
  logic signed [2*XLEN-1:0] fixed;

  always_comb begin
    prod_s = $signed(prod);
    // Negating a zero product gives zero, so no special case is needed
    fixed  = neg ? -prod_s : prod_s;
    result = (op == MUL) ? fixed[XLEN-1:0] : fixed[2*XLEN-1:XLEN];
  end

endmodule

// File: rtl/multiply_control_unit.sv
// Two-stage elastic wrapper around an external 32x32 unsigned multiplier:
// S1 holds operand magnitudes for the core, S2 holds the registered product.
module multiply_control_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [1:0]        op_i,
  input  logic [XLEN-1:0]   operand1_i,
  input  logic [XLEN-1:0]   operand2_i,
  input  logic [TAG_W-1:0]  rd_i,
  output logic [XLEN-1:0]   mult_a_o,
  output logic [XLEN-1:0]   mult_b_o,
  input  logic [2*XLEN-1:0] mult_p_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [XLEN-1:0]   result_o,
  output logic [TAG_W-1:0]  rd_o,
  output logic              busy_o
);

  import mul_pkg::*;

  // Two's-complement magnitude; the most negative value maps to itself,
  // which is correct once read back as unsigned.
  function automatic logic [XLEN-1:0] mag(input logic signed [XLEN-1:0] v);
    return v[XLEN-1] ? -v : v;
  endfunction

  s1_t  s1_p0;
  s1_t  s1_p1;
  s2_t  s2_p2;
  logic vld_p1;
  logic vld_p2;
  logic adv1;
  logic adv2;
  logic accept;

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;

  assign adv2       = !vld_p2 || out_ready_i;
  assign adv1       = !vld_p1 || adv2;
  assign in_ready_o = adv1 && !flush_i;
  assign accept     = in_valid_i && in_ready_o;

  assign a_s = $signed(operand1_i);
  assign b_s = $signed(operand2_i);

  always_comb begin
    s1_p0.op  = mul_op_e'(op_i);
    s1_p0.rd  = rd_i;
    s1_p0.neg = 1'b0;
    s1_p0.a   = operand1_i;
    s1_p0.b   = operand2_i;
    case (mul_op_e'(op_i))
      MULH: begin
        s1_p0.a   = mag(a_s);
        s1_p0.b   = mag(b_s);
        s1_p0.neg = a_s[XLEN-1] ^ b_s[XLEN-1];
      end
      MULHSU: begin
        s1_p0.a   = mag(a_s);
        s1_p0.neg = a_s[XLEN-1];
      end
      default: ;
    endcase
  end

  // Stage boundary p0 -> p1 (issue to core inputs) and p1 -> p2 (product capture)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      s1_p1  <= '0;
      s2_p2  <= '0;
    end else begin
      if (flush_i)     vld_p1 <= 1'b0;
      else if (accept) vld_p1 <= 1'b1;
      else if (adv2)   vld_p1 <= 1'b0;

      if (flush_i)               vld_p2 <= 1'b0;
      else if (vld_p1 && adv2)   vld_p2 <= 1'b1;
      else if (out_ready_i)      vld_p2 <= 1'b0;

      if (accept) s1_p1 <= s1_p0;
      if (vld_p1 && adv2 && !flush_i) begin
        s2_p2.op   <= s1_p1.op;
        s2_p2.rd   <= s1_p1.rd;
        s2_p2.neg  <= s1_p1.neg;
        s2_p2.prod <= mult_p_i;
      end
    end
  end

  assign mult_a_o    = s1_p1.a;
  assign mult_b_o    = s1_p1.b;
  assign out_valid_o = vld_p2;
  assign rd_o        = s2_p2.rd;
  assign busy_o      = vld_p1 || vld_p2;

  mul_sign_fix u_sign_fix (
    .prod   (s2_p2.prod),
    .neg    (s2_p2.neg),
    .op     (s2_p2.op),
    .result (result_o)
  );

endmodule
